// File: rtl/dev_ram_arbiter_if.sv
// Purpose: groups the requester-side and RAM-side signals of the device RAM arbiter.
// Latency: none (wiring only).
// Backpressure: none here; requesters see completion only through ack, and the RAM side through ram_ready.
//
// Ports (signals):
//   req_stb/req_we/req_addr/req_wdata  per-requester one-cycle request strobe and its sampled fields
//   ack/rdata                          per-requester completion pulse and shared read data
//   overrun/timeout_err/busy           sticky status flags and FSM activity
//   ram_addr/ram_cs/ram_we/ram_din     single RAM transaction port (ram_cs qualifies the rest)
//   ram_dout/ram_ready                 RAM response
// The "slave" modport is the arbiter's view; "master" is the devices + RAM controller side.
interface dev_ram_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 27
);
    logic [NREQ-1:0]             req_stb;
    logic [NREQ-1:0]             req_we;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][7:0]        req_wdata;
    logic [NREQ-1:0]             ack;
    logic [7:0]                  rdata;
    logic [NREQ-1:0]             overrun;
    logic                        timeout_err;
    logic                        busy;
    logic [ADDR_W-1:0]           ram_addr;
    logic                        ram_cs;
    logic                        ram_we;
    logic [7:0]                  ram_din;
    logic [7:0]                  ram_dout;
    logic                        ram_ready;

    modport slave (
        input  req_stb, req_we, req_addr, req_wdata, ram_dout, ram_ready,
        output ack, rdata, overrun, timeout_err, busy, ram_addr, ram_cs, ram_we, ram_din
    );

    modport master (
        output req_stb, req_we, req_addr, req_wdata, ram_dout, ram_ready,
        input  ack, rdata, overrun, timeout_err, busy, ram_addr, ram_cs, ram_we, ram_din
    );
endinterface

// File: rtl/dev_ram_arbiter.sv
// Purpose: round-robin arbiter sharing one device-side RAM port among NREQ one-shot requesters.
// Latency: strobe in cycle 0 -> ram_cs in cycle 2 -> ack in cycle 4 at the earliest (ram_ready in cycle 3).
// Backpressure: one outstanding request per slot; a strobe on a pending slot is dropped and flagged in overrun.
//
// Ports: clk, reset_n (async, active-low) plus the "slave" modport of dev_ram_arbiter_if.
// All outputs are registered. TIMEOUT bounds the WAIT state; a timed-out transaction
// completes with rdata=0xFF and raises the sticky timeout_err.
module dev_ram_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dev_ram_arbiter_if.slave      bus
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Request slots
    logic [NREQ-1:0]             pend;
    logic [NREQ-1:0]             slot_we;
    logic [NREQ-1:0][ADDR_W-1:0] slot_addr;
    logic [NREQ-1:0][7:0]        slot_wdata;
    logic [NREQ-1:0]             overrun_q;
    logic [NREQ-1:0]             done_vec;

    // Arbitration
    logic [GW-1:0] grant, grant_nxt;
    logic [GW-1:0] last, last_nxt;
    logic [GW-1:0] win_idx;
    logic [GW-1:0] scan_idx;
    logic          win_vld;

    // Registered outputs and their next values
    logic [NREQ-1:0]   ack_q, ack_nxt;
    logic              ram_cs_q, ram_cs_nxt;
    logic              ram_we_q, ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_nxt;
    logic [7:0]        ram_din_q, ram_din_nxt;
    logic [7:0]        rdata_q, rdata_nxt;
    logic              terr_q, terr_nxt;
    logic              busy_q, busy_nxt;
    logic [7:0]        tmo_cnt, cnt_nxt;
    logic              tmo_hit;

    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT));

    // Slot being retired this cycle; a strobe on it is a fresh request, not an overrun.
    assign done_vec = (state == S_DONE) ? (NREQ'(1) << grant) : '0;

    // Round-robin search beginning just after the last winner.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = GW'((int'(last) + k) % NREQ);
            if (!win_vld && pend[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Slot registers: set wins over the DONE-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend       <= '0;
            slot_we    <= '0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            overrun_q  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_stb[i]) begin
                    if (!pend[i] || done_vec[i]) begin
                        pend[i]       <= 1'b1;
                        slot_we[i]    <= bus.req_we[i];
                        slot_addr[i]  <= bus.req_addr[i];
                        slot_wdata[i] <= bus.req_wdata[i];
                    end else begin
                        overrun_q[i]  <= 1'b1;
                    end
                end else if (done_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_vld) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (bus.ram_ready || tmo_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs, computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        ack_nxt      = '0;
        ram_cs_nxt   = 1'b0;
        ram_we_nxt   = ram_we_q;
        ram_addr_nxt = ram_addr_q;
        ram_din_nxt  = ram_din_q;
        rdata_nxt    = rdata_q;
        terr_nxt     = terr_q;
        grant_nxt    = grant;
        last_nxt     = last;
        cnt_nxt      = tmo_cnt;
        busy_nxt     = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                // Winner slot is pending, so its contents cannot change before ISSUE.
                if (win_vld) begin
                    grant_nxt    = win_idx;
                    last_nxt     = win_idx;
                    ram_cs_nxt   = 1'b1;
                    ram_we_nxt   = slot_we[win_idx];
                    ram_addr_nxt = slot_addr[win_idx];
                    ram_din_nxt  = slot_wdata[win_idx];
                end
            end
            S_ISSUE: cnt_nxt = '0;
            S_WAIT: begin
                if (bus.ram_ready) begin
                    if (!ram_we_q) rdata_nxt = bus.ram_dout;
                    ack_nxt = NREQ'(1) << grant;
                end else if (tmo_hit) begin
                    rdata_nxt = 8'hFF;
                    terr_nxt  = 1'b1;
                    ack_nxt   = NREQ'(1) << grant;
                end else begin
                    cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q      <= '0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rdata_q    <= 8'hFF;
            terr_q     <= 1'b0;
            busy_q     <= 1'b0;
            grant      <= '0;
            last       <= GW'(NREQ - 1);
            tmo_cnt    <= '0;
        end else begin
            ack_q      <= ack_nxt;
            ram_cs_q   <= ram_cs_nxt;
            ram_we_q   <= ram_we_nxt;
            ram_addr_q <= ram_addr_nxt;
            ram_din_q  <= ram_din_nxt;
            rdata_q    <= rdata_nxt;
            terr_q     <= terr_nxt;
            busy_q     <= busy_nxt;
            grant      <= grant_nxt;
            last       <= last_nxt;
            tmo_cnt    <= cnt_nxt;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = busy_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_cs      = ram_cs_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_din     = ram_din_q;
endmodule

// File: tb/tb_dev_ram_arbiter.sv
// Purpose: directed self-checking bench for dev_ram_arbiter (NREQ=4, TIMEOUT=8).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: a simple RAM responder answers ram_cs after rsp_lat cycles (0 = never).
module tb_dev_ram_arbiter;
    localparam int NREQ    = 4;
    localparam int ADDR_W  = 27;
    localparam int TIMEOUT = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dev_ram_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

    dev_ram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    int                rsp_lat  = 1;
    logic [7:0]        rsp_data = 8'hA5;
    int                cnt_down = 0;
    int                cs_cnt   = 0;
    int                ack_cnt  = 0;
    logic [ADDR_W-1:0] last_cs_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        bus.req_stb   = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // Leaves the caller at a falling edge with reset just released (cycle 0).
    task automatic do_reset();
        tick();
        reset_n  = 1'b0;
        clear_reqs();
        cnt_down = 0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // RAM controller model plus transaction/ack counters.
    initial begin : responder
        bus.ram_ready = 1'b0;
        bus.ram_dout  = 8'h00;
        forever begin
            @(negedge clk);
            bus.ram_ready = 1'b0;
            if (cnt_down > 0) begin
                cnt_down--;
                if (cnt_down == 0) begin
                    bus.ram_ready = 1'b1;
                    bus.ram_dout  = rsp_data;
                end
            end
            if (bus.ram_cs) begin
                cs_cnt++;
                last_cs_addr = bus.ram_addr;
                if (rsp_lat > 0) cnt_down = rsp_lat;
            end
            if (bus.ack != '0) ack_cnt++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [ADDR_W-1:0] got_addr [6];
        int                got_t    [6];
        logic [ADDR_W-1:0] exp_addr [6];
        int n_cs, n_ack, cs0, ack0;

        clear_reqs();
        reset_n = 1'b0;
        repeat (2) tick();
        // Reset values
        chk("rst_ack",      32'(bus.ack), 0);
        chk("rst_ram_cs",   32'(bus.ram_cs), 0);
        chk("rst_ram_we",   32'(bus.ram_we), 0);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        chk("rst_ram_din",  32'(bus.ram_din), 0);
        chk("rst_rdata",    32'(bus.rdata), 32'hFF);
        chk("rst_overrun",  32'(bus.overrun), 0);
        chk("rst_tmo_err",  32'(bus.timeout_err), 0);

        // ---- Single read, minimum latency ----
        do_reset();
        rsp_lat = 1; rsp_data = 8'hA5;
        bus.req_stb = 4'b0001; bus.req_we[0] = 1'b0; bus.req_addr[0] = 27'h12345;
        tick(); bus.req_stb = '0;                               // cycle 1
        chk("t1_c1_cs",   32'(bus.ram_cs), 0);
        chk("t1_c1_busy", 32'(bus.busy), 0);
        tick();                                                 // cycle 2
        chk("t1_c2_cs",   32'(bus.ram_cs), 1);
        chk("t1_c2_addr", 32'(bus.ram_addr), 32'h12345);
        chk("t1_c2_we",   32'(bus.ram_we), 0);
        chk("t1_c2_busy", 32'(bus.busy), 1);
        tick();                                                 // cycle 3
        chk("t1_c3_cs",   32'(bus.ram_cs), 0);
        chk("t1_c3_ack",  32'(bus.ack), 0);
        tick();                                                 // cycle 4
        chk("t1_c4_ack",  32'(bus.ack), 32'b0001);
        chk("t1_c4_rdata", 32'(bus.rdata), 32'hA5);
        tick();                                                 // cycle 5
        chk("t1_c5_ack",  32'(bus.ack), 0);
        chk("t1_c5_busy", 32'(bus.busy), 0);
        chk("t1_c5_rdata_held", 32'(bus.rdata), 32'hA5);

        // ---- Round-robin: all strobe, each re-strobes on its own ack ----
        do_reset();
        rsp_lat = 1;
        for (int i = 0; i < NREQ; i++) bus.req_addr[i] = ADDR_W'(32'h100 + i);
        bus.req_stb = 4'b1111;
        exp_addr = '{27'h100, 27'h101, 27'h102, 27'h103, 27'h200, 27'h201};
        n_cs = 0; n_ack = 0;
        for (int t = 1; t < 200 && n_cs < 6; t++) begin
            tick();
            bus.req_stb = '0;
            if (bus.ack != '0 && n_ack < NREQ) begin
                for (int i = 0; i < NREQ; i++)
                    if (bus.ack[i]) bus.req_addr[i] = ADDR_W'(32'h200 + i);
                bus.req_stb = bus.ack;
                n_ack++;
            end
            if (bus.ram_cs) begin
                got_addr[n_cs] = bus.ram_addr;
                got_t[n_cs]    = t;
                n_cs++;
            end
        end
        bus.req_stb = '0;
        chk("rr_count", 32'(n_cs), 6);
        for (int k = 0; k < 6; k++)
            if (k < n_cs) chk($sformatf("rr_grant%0d", k), 32'(got_addr[k]), 32'(exp_addr[k]));
        if (n_cs >= 2) chk("rr_cs_spacing", 32'(got_t[1] - got_t[0]), 4);
        repeat (20) tick();
        chk("rr_overrun", 32'(bus.overrun), 0);
        chk("rr_idle",    32'(bus.busy), 0);

        // ---- Overrun: second strobe while request 1 is in flight ----
        do_reset();
        rsp_lat = 3;
        cs0 = cs_cnt; ack0 = ack_cnt;
        bus.req_stb = 4'b0010; bus.req_addr[1] = 27'h111;      // cycle 0
        tick(); bus.req_stb = '0;                               // cycle 1
        tick(); bus.req_stb = 4'b0010; bus.req_addr[1] = 27'h222; // cycle 2
        tick(); bus.req_stb = '0;                               // cycle 3
        chk("ov_flag_c3", 32'(bus.overrun), 32'b0010);
        repeat (20) tick();
        chk("ov_cs_count",  32'(cs_cnt - cs0), 1);
        chk("ov_ack_count", 32'(ack_cnt - ack0), 1);
        chk("ov_addr",      32'(last_cs_addr), 32'h111);
        chk("ov_sticky",    32'(bus.overrun), 32'b0010);

        // ---- Set-wins: re-strobe requester 2 in its DONE cycle ----
        do_reset();
        rsp_lat = 1; rsp_data = 8'h6E;
        bus.req_stb = 4'b0100; bus.req_addr[2] = 27'h333;
        bus.req_we[2] = 1'b1; bus.req_wdata[2] = 8'h77;         // cycle 0
        tick(); bus.req_stb = '0;                               // cycle 1
        tick();                                                 // cycle 2
        chk("sw_c2_cs",  32'(bus.ram_cs), 1);
        chk("sw_c2_addr", 32'(bus.ram_addr), 32'h333);
        chk("sw_c2_we",  32'(bus.ram_we), 1);
        chk("sw_c2_din", 32'(bus.ram_din), 32'h77);
        repeat (2) tick();                                      // cycle 4 (DONE)
        chk("sw_c4_ack",   32'(bus.ack), 32'b0100);
        chk("sw_c4_rdata_write_keeps", 32'(bus.rdata), 32'hFF);
        bus.req_stb = 4'b0100; bus.req_addr[2] = 27'h444; bus.req_we[2] = 1'b0;
        tick(); bus.req_stb = '0;                               // cycle 5
        chk("sw_c5_ack", 32'(bus.ack), 0);
        tick();                                                 // cycle 6
        chk("sw_c6_cs",   32'(bus.ram_cs), 1);
        chk("sw_c6_addr", 32'(bus.ram_addr), 32'h444);
        chk("sw_c6_we",   32'(bus.ram_we), 0);
        repeat (2) tick();                                      // cycle 8
        chk("sw_c8_ack",   32'(bus.ack), 32'b0100);
        chk("sw_c8_rdata", 32'(bus.rdata), 32'h6E);
        chk("sw_overrun",  32'(bus.overrun), 0);

        // ---- Timeout then normal completion of the next request ----
        do_reset();
        rsp_lat = 0; rsp_data = 8'h3C;
        bus.req_stb = 4'b0001; bus.req_addr[0] = 27'h50;        // cycle 0
        tick(); bus.req_stb = 4'b0010; bus.req_addr[1] = 27'h51; // cycle 1
        tick(); bus.req_stb = '0;                               // cycle 2
        chk("to_c2_cs",   32'(bus.ram_cs), 1);
        chk("to_c2_addr", 32'(bus.ram_addr), 32'h50);
        tick(); rsp_lat = 1;                                    // cycle 3
        repeat (8) tick();                                      // cycle 11
        chk("to_c11_ack",  32'(bus.ack), 0);
        chk("to_c11_terr", 32'(bus.timeout_err), 0);
        tick();                                                 // cycle 12
        chk("to_c12_ack",   32'(bus.ack), 32'b0001);
        chk("to_c12_rdata", 32'(bus.rdata), 32'hFF);
        chk("to_c12_terr",  32'(bus.timeout_err), 1);
        repeat (2) tick();                                      // cycle 14
        chk("to_c14_cs",   32'(bus.ram_cs), 1);
        chk("to_c14_addr", 32'(bus.ram_addr), 32'h51);
        repeat (2) tick();                                      // cycle 16
        chk("to_c16_ack",   32'(bus.ack), 32'b0010);
        chk("to_c16_rdata", 32'(bus.rdata), 32'h3C);
        chk("to_c16_terr_sticky", 32'(bus.timeout_err), 1);

        // ---- Asynchronous reset during WAIT ----
        do_reset();
        rsp_lat = 0;
        bus.req_stb = 4'b0001; bus.req_addr[0] = 27'h66; bus.req_we[0] = 1'b1; bus.req_wdata[0] = 8'h99;
        tick(); bus.req_stb = 4'b0010; bus.req_addr[1] = 27'h67;
        tick(); bus.req_stb = '0;                               // cycle 2
        repeat (2) tick();                                      // cycle 4 (WAIT)
        chk("ar_busy_before", 32'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("ar_busy",     32'(bus.busy), 0);
        chk("ar_ram_addr", 32'(bus.ram_addr), 0);
        chk("ar_ram_we",   32'(bus.ram_we), 0);
        chk("ar_ram_din",  32'(bus.ram_din), 0);
        chk("ar_rdata",    32'(bus.rdata), 32'hFF);
        chk("ar_ack",      32'(bus.ack), 0);
        tick(); tick();
        reset_n = 1'b1;
        cs0 = cs_cnt; ack0 = ack_cnt;
        repeat (15) tick();
        chk("ar_no_ack_after", 32'(ack_cnt - ack0), 0);
        chk("ar_no_cs_after",  32'(cs_cnt - cs0), 0);
        chk("ar_idle_after",   32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dev_ram_arbiter.md
# dev_ram_arbiter

Shares the single device-side RAM port (`ram_addr`/`ram_cs`) among up to `NREQ` memory-hungry devices, such as the kanji ROM and OCM boot loader. Each device issues one-cycle request strobes. The arbiter latches each request, grants in round-robin order, drives one RAM transaction at a time, waits for the SDRAM controller's ready, and returns a one-cycle ack with read data. The block replaces the AND/OR merging of device RAM outputs inside `devices`.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `ADDR_W`, 27, RAM byte address width
- `TIMEOUT`, 255, maximum WAIT cycles before a forced completion (1..255)

Ports:
- `clk`  in  1  system clock; one clock domain
- `reset_n`  in  1  reset, asynchronous, active-low
- `req_stb`  in  NREQ  one-cycle request strobe per requester
- `req_we`  in  NREQ  1 = write, 0 = read; sampled with the strobe
- `req_addr`  in  NREQ×ADDR_W  request address; sampled with the strobe
- `req_wdata`  in  NREQ×8  write data; sampled with the strobe
- `ack`  out  NREQ  one-cycle completion pulse per requester
- `rdata`  out  8  read data; valid in the `ack` cycle and held until the next completion
- `overrun`  out  NREQ  sticky flag: a strobe was dropped because a request was already pending
- `timeout_err`  out  1  sticky flag: a transaction ended by timeout
- `busy`  out  1  high whenever the FSM is not in IDLE
- `ram_addr`  out  ADDR_W  RAM address
- `ram_cs`  out  1  RAM request, one-cycle pulse
- `ram_we`  out  1  RAM write enable, valid with `ram_cs`
- `ram_din`  out  8  RAM write data
- `ram_dout`  in  8  RAM read data, valid with `ram_ready`
- `ram_ready`  in  1  RAM transaction complete, one-cycle pulse

## Operation
- Each requester has a slot register: pending, we, addr and wdata.
- A strobe on a slot that is not pending sets pending and captures we, addr and wdata on the same edge.
- A strobe on a pending slot is dropped. The slot contents stay unchanged and `overrun[i]` is set.
  - Exception: if the slot is being completed in that cycle (DONE state, grant = i), the new request is captured and pending stays 1. Set wins over clear.
- Round-robin pointer `last` resets to NREQ-1. The search starts at `last+1` mod NREQ and wraps; the lowest index reached first wins.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any slot is pending, register the winner into `grant`, update `last` to the winner, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive `ram_cs`=1 for exactly one cycle, with `ram_addr`/`ram_we`/`ram_din` taken from slot[grant]. Clear the timeout counter. Go to WAIT.
  - WAIT: if `ram_ready`=1, capture `ram_dout` into `rdata` (reads only; writes leave `rdata` unchanged) and go to DONE.
    - Otherwise the counter increments. When it reaches TIMEOUT, set `rdata`=0xFF, set `timeout_err`, and go to DONE.
  - DONE: pulse `ack[grant]`, clear pending[grant] (subject to the set-wins rule), and go to IDLE.
- `ram_ready` is ignored outside WAIT.
- `ram_addr`/`ram_we`/`ram_din` hold their last values outside ISSUE; only `ram_cs` qualifies them.
- Sticky flags (`overrun`, `timeout_err`) clear only on reset.

## Timing
- Reset values:
  - `ack`=0, `ram_cs`=0, `ram_we`=0, `busy`=0
  - `ram_addr`=0, `ram_din`=0, `rdata`=0xFF
  - `overrun`=0, `timeout_err`=0
  - all slots not pending; FSM in IDLE; `last`=NREQ-1
- All outputs are registered.
- Minimum latency: strobe in cycle 0 → pending in cycle 1 (IDLE picks the winner) → `ram_cs` in cycle 2 → earliest `ram_ready` in cycle 3 → `ack` in cycle 4.
- Back-to-back transactions: a new `ram_cs` can appear at most every 4 cycles, since IDLE costs one cycle per grant.
- Timeout: with no `ram_ready`, `ack` arrives TIMEOUT+2 cycles after `ram_cs`.
- Reset during WAIT or DONE: the transaction is abandoned, no `ack` is issued, and all pending requests are lost. Requesters must re-issue after reset.

## Test plan
- Single read: strobe `req_stb`=0001, addr 0x12345, we=0; `ram_ready` one cycle after `ram_cs` with `ram_dout`=0xA5 → `ram_cs` in cycle 2 with `ram_addr`=0x12345, `ack`=0001 in cycle 4, `rdata`=0xA5.
- Round-robin fairness: all four requesters strobe in the same cycle, then each re-strobes on its own ack → grant order 0,1,2,3,0,1 with no starvation.
- Overrun: strobe requester 1 twice, 1 cycle apart, while RAM is stalled → second strobe dropped, `overrun`=0010, and RAM sees the first address only.
- Set-wins: re-strobe requester 2 exactly in its DONE cycle with a new address → pending stays 1, second transaction issued with the new address, `overrun` stays 0.
- Timeout: `TIMEOUT`=8 and `ram_ready` never asserted → `ack` 10 cycles after `ram_cs`, `rdata`=0xFF, `timeout_err`=1, and the next pending request proceeds normally.
- Async reset in WAIT: drop `reset_n` mid-transaction → all outputs go to reset values immediately with no clock edge, and no `ack` is issued after release.
